// File: rtl/cordic_block_if.sv
// Handshake and data bundle for cordic_block: start strobe with operands in,
// registered results with busy/done status out.
interface cordic_block_if #(
    parameter int WIDTH = 32
);
    logic                    valid;
    logic signed [WIDTH-1:0] x0;
    logic signed [WIDTH-1:0] y0;
    logic signed [WIDTH-1:0] z0;
    logic        [WIDTH-1:0] n;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
    logic                    busy;
    logic                    done;

    modport master (
        output valid, x0, y0, z0, n,
        input  x, y, z, busy, done
    );

    modport slave (
        input  valid, x0, y0, z0, n,
        output x, y, z, busy, done
    );
endinterface

// File: rtl/cordic_block.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock on a shared datapath.
// Optional output gain compensation is enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_block #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    cordic_block_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] wx_q, wx_d;
    logic signed [WIDTH-1:0] wy_q, wy_d;
    logic signed [WIDTH-1:0] wz_q, wz_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic        [CNT_W-1:0] i_q, i_d;
    logic        [CNT_W-1:0] n_q, n_d;
    logic                    done_q, done_d;

    logic signed [WIDTH-1:0] x_shift;
    logic signed [WIDTH-1:0] y_shift;
    logic signed [WIDTH-1:0] atan_i;

    // arctan(2^-i) stored in Q16.16, rescaled to the configured fraction width;
    // entries beyond the table are below one LSB and read as zero.
    function automatic logic signed [WIDTH-1:0] atan_lut(input logic [CNT_W-1:0] idx);
        logic signed [WIDTH-1:0] a;
        case (int'(idx))
            0:       a = WIDTH'(51472);
            1:       a = WIDTH'(30386);
            2:       a = WIDTH'(16055);
            3:       a = WIDTH'(8150);
            4:       a = WIDTH'(4091);
            5:       a = WIDTH'(2047);
            6:       a = WIDTH'(1024);
            7:       a = WIDTH'(512);
            8:       a = WIDTH'(256);
            9:       a = WIDTH'(128);
            10:      a = WIDTH'(64);
            11:      a = WIDTH'(32);
            12:      a = WIDTH'(16);
            13:      a = WIDTH'(8);
            14:      a = WIDTH'(4);
            15:      a = WIDTH'(2);
            default: a = '0;
        endcase
        if (FRAC >= 16) begin
            a = a <<< (FRAC - 16);
        end else begin
            a = a >>> (16 - FRAC);
        end
        return a;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_count(input logic [WIDTH-1:0] cnt);
        if (cnt > WIDTH'(MAX_ITER)) begin
            return CNT_W'(MAX_ITER);
        end
        return CNT_W'(cnt);
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [WIDTH-1:0] K_GAIN = WIDTH'(39797);

    // Multiply by 1/gain in full precision, then drop the extra fraction bits.
    function automatic logic signed [WIDTH-1:0] scale_out(input logic signed [WIDTH-1:0] v);
        logic signed [2*WIDTH-1:0] prod;
        prod = (2*WIDTH)'(v) * (2*WIDTH)'(K_GAIN);
        return WIDTH'(prod >>> FRAC);
    endfunction
`else
    function automatic logic signed [WIDTH-1:0] scale_out(input logic signed [WIDTH-1:0] v);
        return v;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        wz_d    = wz_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        n_d     = n_q;
        done_d  = 1'b0;
        x_shift = wx_q >>> i_q;
        y_shift = wy_q >>> i_q;
        atan_i  = atan_lut(i_q);

        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    wx_d    = bus.x0;
                    wy_d    = bus.y0;
                    wz_d    = bus.z0;
                    n_d     = clamp_count(bus.n);
                    i_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The cycle that finds the count exhausted publishes the results,
                // so done rises N+1 edges after the start strobe was taken.
                if (i_q == n_q) begin
                    x_d     = scale_out(wx_q);
                    y_d     = scale_out(wy_q);
                    z_d     = wz_q;
                    done_d  = 1'b1;
                    state_d = OUT;
                end else begin
                    if (!wz_q[WIDTH-1]) begin
                        wx_d = wx_q - y_shift;
                        wy_d = wy_q + x_shift;
                        wz_d = wz_q - atan_i;
                    end else begin
                        wx_d = wx_q + y_shift;
                        wy_d = wy_q - x_shift;
                        wz_d = wz_q + atan_i;
                    end
                    i_d = i_q + 1'b1;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wx_q    <= '0;
            wy_q    <= '0;
            wz_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            wz_q    <= wz_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end

    assign bus.x    = x_q;
    assign bus.y    = y_q;
    assign bus.z    = z_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q == RUN) || (state_q == OUT);

endmodule

// File: tb/tb_cordic_block.sv
// Bench for cordic_block: reference vectors, randomized operands against a
// behavioural model, reset abort and strobe-while-busy sequences.
module tb_cordic_block;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_block_if #(.WIDTH(32)) bus ();

    cordic_block #(.WIDTH(32), .FRAC(16), .MAX_ITER(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int atan_tab [16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                          256, 128, 64, 32, 16, 8, 4, 2};

    typedef struct {
        int          x0;
        int          y0;
        int          z0;
        int unsigned n;
        int          lat;
        int          ex;
        int          ey;
        int          ez;
        int          tol_xy;
        int          tol_z;
    } vec_t;

    vec_t vecs [6];

    function automatic int gc(input int v);
        longint p;
        p = longint'(v) * 64'sd39797;
        return int'(p >>> 16);
    endfunction

    function automatic int out_scale(input int v);
`ifdef CORDIC_GAIN_COMP_EN
        return gc(v);
`else
        return v;
`endif
    endfunction

    // Rotation-mode CORDIC written as a plain loop over 32-bit wrapping ints.
    task automatic model(input int x0, input int y0, input int z0, input int unsigned n,
                         output int rx, output int ry, output int rz);
        int x, y, z, xs, ys, cnt;
        x = x0; y = y0; z = z0;
        cnt = (n > 16) ? 16 : int'(n);
        for (int i = 0; i < cnt; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (z >= 0) begin
                x = x - ys; y = y + xs; z = z - atan_tab[i];
            end else begin
                x = x + ys; y = y - xs; z = z + atan_tab[i];
            end
        end
        rx = out_scale(x);
        ry = out_scale(y);
        rz = z;
    endtask

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        longint diff;
        total++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic start_op(input int x0, input int y0, input int z0, input int unsigned n);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.x0 = x0; bus.y0 = y0; bus.z0 = z0; bus.n = n;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_and_check(input string tag, input int x0, input int y0, input int z0,
                                 input int unsigned n, input int lat, input int ex, input int ey,
                                 input int ez, input int tol_xy, input int tol_z);
        int cyc;
        start_op(x0, y0, z0, n);
        wait_done(cyc);
        check({tag, ".latency"}, cyc, lat, 0);
        check({tag, ".x"}, longint'(bus.x), ex, tol_xy);
        check({tag, ".y"}, longint'(bus.y), ey, tol_xy);
        check({tag, ".z"}, longint'(bus.z), ez, tol_z);
        @(negedge clk);
        check({tag, ".done_pulse"}, bus.done, 0, 0);
        check({tag, ".busy_after"}, bus.busy, 0, 0);
    endtask

    initial begin
        int cyc, pulses, rx, ry, rz, x0, y0, z0;
        int unsigned n;

        vecs[0] = '{65536, 0,  102943, 16, 17, 0,      107922,  0,      8,  4};
        vecs[1] = '{65536, 0,  0,      16, 17, 107922, 0,       0,      16, 4};
        vecs[2] = '{100,  -200, 300,   0,  1,  100,    -200,    300,    0,  0};
        vecs[3] = '{65536, 0,  102943, 40, 17, 0,      107922,  0,      8,  4};
        vecs[4] = '{65536, 0, -102943, 16, 17, 0,      -107922, 0,      8,  4};
        vecs[5] = '{65536, 0,  0,      1,  2,  65536,  65536,   -51472, 0,  0};
        foreach (vecs[k]) begin
            vecs[k].ex = out_scale(vecs[k].ex);
            vecs[k].ey = out_scale(vecs[k].ey);
        end

        rst_n = 1'b0;
        bus.valid = 1'b0;
        bus.x0 = 0; bus.y0 = 0; bus.z0 = 0; bus.n = 0;
        repeat (3) @(negedge clk);
        check("reset.x", longint'(bus.x), 0, 0);
        check("reset.y", longint'(bus.y), 0, 0);
        check("reset.z", longint'(bus.z), 0, 0);
        check("reset.busy", bus.busy, 0, 0);
        check("reset.done", bus.done, 0, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_and_check($sformatf("vec%0d", k), vecs[k].x0, vecs[k].y0, vecs[k].z0, vecs[k].n,
                          vecs[k].lat, vecs[k].ex, vecs[k].ey, vecs[k].ez, vecs[k].tol_xy, vecs[k].tol_z);
        end

        for (int r = 0; r < 24; r++) begin
            if (r % 2 == 0) begin
                x0 = int'($urandom_range(0, 131072)) - 65536;
                y0 = int'($urandom_range(0, 131072)) - 65536;
                z0 = int'($urandom_range(0, 205886)) - 102943;
            end else begin
                x0 = int'($urandom());
                y0 = int'($urandom());
                z0 = int'($urandom());
            end
            n = $urandom_range(0, 20);
            model(x0, y0, z0, n, rx, ry, rz);
            run_and_check($sformatf("rand%0d", r), x0, y0, z0, n,
                          (n > 16 ? 16 : int'(n)) + 1, rx, ry, rz, 0, 0);
        end

        // Abort a computation with reset part-way through.
        start_op(65536, 0, 102943, 16);
        repeat (5) @(negedge clk);
        check("abort.busy_before", bus.busy, 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.busy", bus.busy, 0, 0);
        check("abort.done", bus.done, 0, 0);
        check("abort.x", longint'(bus.x), 0, 0);
        check("abort.y", longint'(bus.y), 0, 0);
        check("abort.z", longint'(bus.z), 0, 0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        check("abort.no_activity", pulses, 0, 0);
        run_and_check("restart", vecs[0].x0, vecs[0].y0, vecs[0].z0, vecs[0].n,
                      vecs[0].lat, vecs[0].ex, vecs[0].ey, vecs[0].ez, vecs[0].tol_xy, vecs[0].tol_z);

        // Strobes while running and in the output cycle must be ignored.
        start_op(65536, 0, 0, 16);
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            if (cyc < 3) begin
                bus.valid = 1'b1;
                bus.x0 = 100; bus.y0 = -200; bus.z0 = 300; bus.n = 0;
            end else begin
                bus.valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("ignore.latency", cyc, 17, 0);
        check("ignore.x", longint'(bus.x), vecs[1].ex, 16);
        check("ignore.y", longint'(bus.y), vecs[1].ey, 16);
        check("ignore.z", longint'(bus.z), 0, 4);
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        check("ignore.out_busy", bus.busy, 0, 0);
        check("ignore.out_done", bus.done, 0, 0);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        check("ignore.no_restart", pulses, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
